// File: rtl/huff_enc_ctrl_pkg.sv
// Shared constants, state encodings and payload types for the Huffman encoder controller.
package huff_enc_ctrl_pkg;

    localparam int unsigned MAX_STRING_LENGTH = 32;
    localparam int unsigned MAX_OUTPUT_SIZE   = 16;
    localparam int unsigned CHAR_W            = 7;
    localparam int unsigned ST_W              = 3;

    localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [ST_W-1:0] ST_LOAD   = 3'd1;
    localparam logic [ST_W-1:0] ST_RUN    = 3'd2;
    localparam logic [ST_W-1:0] ST_SETTLE = 3'd3;
    localparam logic [ST_W-1:0] ST_DRAIN  = 3'd4;

    typedef struct packed {
        logic [CHAR_W-1:0]          ch;
        logic [MAX_OUTPUT_SIZE-1:0] value;
        logic [MAX_OUTPUT_SIZE-1:0] mask;
    } code_entry_t;

    typedef struct packed {
        logic                                   leaf;
        logic [CHAR_W-1:0]                      ch;
        logic [$clog2(MAX_STRING_LENGTH+1)-1:0] freq;
    } node_t;

endpackage

// File: rtl/huff_enc_ctrl_if.sv
// Character-in / code-entry-out handshake bundle for the encoder controller.
interface huff_enc_ctrl_if #(
    parameter int unsigned OUT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       in_char;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [6:0]       out_char;
    logic [OUT_W-1:0] out_value;
    logic [OUT_W-1:0] out_mask;
    logic             out_last;

    modport slave (
        input  in_valid, in_char, in_last, out_ready,
        output in_ready, out_valid, out_char, out_value, out_mask, out_last
    );

    modport master (
        output in_valid, in_char, in_last, out_ready,
        input  in_ready, out_valid, out_char, out_value, out_mask, out_last
    );
endinterface

// File: rtl/huff_enc_ctrl_code_table.sv
// Snapshot of the encoder code table with a registered indexed read port for draining.
module huff_enc_ctrl_code_table
    import huff_enc_ctrl_pkg::*;
#(
    parameter int unsigned MAX_LEN = MAX_STRING_LENGTH,
    parameter int unsigned OUT_W   = MAX_OUTPUT_SIZE,
    parameter int unsigned IDX_W   = 6
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             ld,
    input  logic                             degen,
    input  logic [CHAR_W-1:0]                fill_char,
    input  logic [MAX_LEN-1:0][CHAR_W-1:0]   ld_char,
    input  logic [MAX_LEN-1:0][OUT_W-1:0]    ld_value,
    input  logic [MAX_LEN-1:0][OUT_W-1:0]    ld_mask,
    input  logic                             rd_en,
    input  logic [IDX_W-1:0]                 rd_idx,
    output logic [CHAR_W-1:0]                rd_char,
    output logic [OUT_W-1:0]                 rd_value,
    output logic [OUT_W-1:0]                 rd_mask
);

    logic [MAX_LEN-1:0][CHAR_W-1:0] tab_char;
    logic [MAX_LEN-1:0][OUT_W-1:0]  tab_value;
    logic [MAX_LEN-1:0][OUT_W-1:0]  tab_mask;
    logic [CHAR_W-1:0]              sel_char;
    logic [OUT_W-1:0]               sel_value;
    logic [OUT_W-1:0]               sel_mask;

    // Indexed read of the stored table
    always_comb begin
        sel_char  = '0;
        sel_value = '0;
        sel_mask  = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (IDX_W'(i) == rd_idx) begin
                sel_char  = tab_char[i];
                sel_value = tab_value[i];
                sel_mask  = tab_mask[i];
            end
        end
    end

    // Capture the whole table; a degenerate table becomes one zero-length code for the fill char
    always_ff @(posedge clk) begin
        if (ld) begin
            tab_char  <= ld_char;
            tab_value <= ld_value;
            tab_mask  <= ld_mask;
            if (degen) begin
                tab_char[0]  <= fill_char;
                tab_value[0] <= '0;
                tab_mask[0]  <= '0;
            end
        end
    end

    // Output entry register: loads entry 0 straight from the snapshot source, then follows rd_idx
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_char  <= '0;
            rd_value <= '0;
            rd_mask  <= '0;
        end else if (ld) begin
            rd_char  <= degen ? fill_char : ld_char[0];
            rd_value <= degen ? '0 : ld_value[0];
            rd_mask  <= degen ? '0 : ld_mask[0];
        end else if (rd_en) begin
            rd_char  <= sel_char;
            rd_value <= sel_value;
            rd_mask  <= sel_mask;
        end
    end

endmodule

// File: rtl/huff_enc_ctrl.sv
// Self-timed sequencer: buffers a string, runs the Huffman encoder, then streams its code table.
module huff_enc_ctrl
    import huff_enc_ctrl_pkg::*;
#(
    parameter int unsigned MAX_LEN    = MAX_STRING_LENGTH,
    parameter int unsigned OUT_W      = MAX_OUTPUT_SIZE,
    parameter int unsigned RUN_CYCLES = 8,
    parameter int unsigned SETTLE     = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    huff_enc_ctrl_if.slave                      ifc,
    output logic [MAX_LEN-1:0][CHAR_W-1:0]      enc_data,
    output logic                                enc_data_en,
    input  logic [$clog2(MAX_LEN+1)-1:0]        enc_unique,
    input  logic [MAX_LEN-1:0][CHAR_W-1:0]      enc_char,
    input  logic [MAX_LEN-1:0][OUT_W-1:0]       enc_value,
    input  logic [MAX_LEN-1:0][OUT_W-1:0]       enc_mask,
    output logic                                busy,
    output logic                                err_overflow
);

    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
    localparam int unsigned CYC_MAX = (RUN_CYCLES > SETTLE) ? RUN_CYCLES : SETTLE;
    localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);

    logic [ST_W-1:0]                state, state_nx;
    logic [LEN_W-1:0]               len, len_nx;
    logic [LEN_W-1:0]               idx, idx_nx;
    logic [LEN_W-1:0]               cnt_n, cnt_n_nx;
    logic [CYC_W-1:0]               cyc, cyc_nx;
    logic                           discard, discard_nx;
    logic [MAX_LEN-1:0][CHAR_W-1:0] data_nx;
    logic                           ovf_nx;
    logic                           snap;
    logic                           rd_en;
    logic [LEN_W-1:0]               rd_idx;
    logic                           xfer;
    logic                           degen;
    logic                           out_last_nx;
    logic [CHAR_W-1:0]              tab_char;
    logic [OUT_W-1:0]               tab_value;
    logic [OUT_W-1:0]               tab_mask;

    assign xfer  = ifc.in_valid & ifc.in_ready;
    assign degen = (enc_unique <= LEN_W'(1));

    // Next-state, buffer and counter logic
    always_comb begin
        state_nx   = state;
        len_nx     = len;
        data_nx    = enc_data;
        discard_nx = discard;
        cyc_nx     = cyc;
        idx_nx     = idx;
        cnt_n_nx   = cnt_n;
        ovf_nx     = 1'b0;
        snap       = 1'b0;
        rd_en      = 1'b0;
        rd_idx     = idx;

        if (xfer && discard && ifc.in_last) begin
            discard_nx = 1'b0;
        end

        case (state)
            ST_IDLE, ST_LOAD: begin
                if (xfer && !discard) begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        if (LEN_W'(i) == len) begin
                            data_nx[i] = ifc.in_char;
                        end
                    end
                    len_nx = len + LEN_W'(1);
                    if (ifc.in_last) begin
                        state_nx = ST_RUN;
                        cyc_nx   = '0;
                    end else if (len == LEN_W'(MAX_LEN - 1)) begin
                        state_nx   = ST_RUN;
                        cyc_nx     = '0;
                        discard_nx = 1'b1;
                        ovf_nx     = 1'b1;
                    end else begin
                        state_nx = ST_LOAD;
                    end
                end
            end
            ST_RUN: begin
                if (cyc == CYC_W'(RUN_CYCLES - 1)) begin
                    state_nx = ST_SETTLE;
                    cyc_nx   = '0;
                end else begin
                    cyc_nx = cyc + CYC_W'(1);
                end
            end
            ST_SETTLE: begin
                if (cyc == CYC_W'(SETTLE - 1)) begin
                    state_nx = ST_DRAIN;
                    snap     = 1'b1;
                    idx_nx   = '0;
                    cnt_n_nx = degen ? LEN_W'(1) : enc_unique;
                end else begin
                    cyc_nx = cyc + CYC_W'(1);
                end
            end
            ST_DRAIN: begin
                if (ifc.out_valid && ifc.out_ready) begin
                    if (ifc.out_last) begin
                        state_nx = ST_IDLE;
                        len_nx   = '0;
                        data_nx  = '0;
                    end else begin
                        idx_nx = idx + LEN_W'(1);
                        rd_en  = 1'b1;
                        rd_idx = idx + LEN_W'(1);
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        out_last_nx = (state_nx == ST_DRAIN) && (idx_nx == cnt_n_nx - LEN_W'(1));
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            len           <= '0;
            idx           <= '0;
            cnt_n         <= '0;
            cyc           <= '0;
            discard       <= 1'b0;
            enc_data      <= '0;
            ifc.in_ready  <= 1'b1;
            enc_data_en   <= 1'b0;
            ifc.out_valid <= 1'b0;
            ifc.out_last  <= 1'b0;
            busy          <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            state         <= state_nx;
            len           <= len_nx;
            idx           <= idx_nx;
            cnt_n         <= cnt_n_nx;
            cyc           <= cyc_nx;
            discard       <= discard_nx;
            enc_data      <= data_nx;
            ifc.in_ready  <= (state_nx == ST_IDLE) || (state_nx == ST_LOAD) || discard_nx;
            enc_data_en   <= (state_nx == ST_RUN);
            ifc.out_valid <= (state_nx == ST_DRAIN);
            ifc.out_last  <= out_last_nx;
            busy          <= (state_nx != ST_IDLE);
            err_overflow  <= ovf_nx;
        end
    end

    huff_enc_ctrl_code_table #(
        .MAX_LEN (MAX_LEN),
        .OUT_W   (OUT_W),
        .IDX_W   (LEN_W)
    ) u_code_table (
        .clk       (clk),
        .reset     (reset),
        .ld        (snap),
        .degen     (degen),
        .fill_char (enc_data[0]),
        .ld_char   (enc_char),
        .ld_value  (enc_value),
        .ld_mask   (enc_mask),
        .rd_en     (rd_en),
        .rd_idx    (rd_idx),
        .rd_char   (tab_char),
        .rd_value  (tab_value),
        .rd_mask   (tab_mask)
    );

    assign ifc.out_char  = tab_char;
    assign ifc.out_value = tab_value;
    assign ifc.out_mask  = tab_mask;

endmodule
